spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 138 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Rate/latency decoder for one neuron: counts spikes over a window of execute
// ticks and latches count, first-spike index and flags until the consumer acks.
module spike_rate_decoder #(
    parameter int COUNT_BITS  = 8,
    parameter int WINDOW_BITS = 8,
    parameter int WINDOW_INIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   spike,
    input  logic [WINDOW_BITS-1:0] window_len,
    input  logic                   window_load,
    input  logic                   read_ack,
    output logic [COUNT_BITS-1:0]  count_out,
    output logic [WINDOW_BITS-1:0] first_spike,
    output logic                   no_spike,
    output logic                   overflow,
    output logic                   valid
);

    typedef enum logic {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [COUNT_BITS-1:0]  ACC_ONE = COUNT_BITS'(1);
    localparam logic [WINDOW_BITS-1:0] WIN_ONE = WINDOW_BITS'(1);

    state_e                 state_q;
    logic [WINDOW_BITS-1:0] window_q;
    logic [WINDOW_BITS-1:0] t_q;
    logic [COUNT_BITS-1:0]  acc_q;
    logic                   captured_q;
    logic [WINDOW_BITS-1:0] first_q;
    logic                   ovf_q;

    logic [COUNT_BITS-1:0]  count_out_q;
    logic [WINDOW_BITS-1:0] first_spike_q;
    logic                   no_spike_q;
    logic                   overflow_q;
    logic                   valid_q;

    // Tick-inclusive views of the accumulator state, used both for the running
    // update and for the result latched on the window's last tick.
    logic [COUNT_BITS-1:0]  acc_d;
    logic                   ovf_d;
    logic [WINDOW_BITS-1:0] first_d;
    logic                   captured_d;
    logic [WINDOW_BITS-1:0] window_d;
    logic                   win_end;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        first_d    = first_q;
        captured_d = captured_q;
        if (spike) begin
            if (&acc_q) ovf_d = 1'b1;
            else        acc_d = acc_q + ACC_ONE;
            if (!captured_q) begin
                first_d    = t_q;
                captured_d = 1'b1;
            end
        end
        window_d = (window_len == '0) ? WIN_ONE : window_len;
        win_end  = (t_q == window_q - WIN_ONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COUNT;
            window_q      <= WINDOW_BITS'(WINDOW_INIT);
            t_q           <= '0;
            acc_q         <= '0;
            captured_q    <= 1'b0;
            first_q       <= '0;
            ovf_q         <= 1'b0;
            count_out_q   <= '0;
            first_spike_q <= '0;
            no_spike_q    <= 1'b0;
            overflow_q    <= 1'b0;
            valid_q       <= 1'b0;
        end else if (window_load) begin
            // Restart beats any window end on the same tick; only an ack in HOLD also lands.
            window_q   <= window_d;
            t_q        <= '0;
            acc_q      <= '0;
            captured_q <= 1'b0;
            ovf_q      <= 1'b0;
            if (state_q == HOLD && read_ack) begin
                valid_q <= 1'b0;
                state_q <= COUNT;
            end
        end else begin
            case (state_q)
                COUNT: begin
                    if (enable) begin
                        if (win_end) begin
                            count_out_q   <= acc_d;
                            first_spike_q <= captured_d ? first_d : '0;
                            no_spike_q    <= !captured_d;
                            overflow_q    <= ovf_d;
                            valid_q       <= 1'b1;
                            t_q           <= '0;
                            acc_q         <= '0;
                            captured_q    <= 1'b0;
                            ovf_q         <= 1'b0;
                            state_q       <= HOLD;
                        end else begin
                            t_q        <= t_q + WIN_ONE;
                            acc_q      <= acc_d;
                            ovf_q      <= ovf_d;
                            first_q    <= first_d;
                            captured_q <= captured_d;
                        end
                    end
                end
                HOLD: begin
                    if (read_ack) begin
                        valid_q <= 1'b0;
                        state_q <= COUNT;
                    end
                end
                default: state_q <= COUNT;
            endcase
        end
    end

    assign count_out   = count_out_q;
    assign first_spike = first_spike_q;
    assign no_spike    = no_spike_q;
    assign overflow    = overflow_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default-width instance plus a 2-bit
// counter instance sharing stimulus; expected results flow through a scoreboard queue.
module tb_spike_rate_decoder;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] first;
        logic       nos;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       spike = 1'b0;
    logic [7:0] window_len = '0;
    logic       window_load = 1'b0;
    logic       read_ack = 1'b0;

    logic [7:0] count_a;
    logic [7:0] first_a;
    logic       nos_a, ovf_a, valid_a;
    logic [1:0] count_b;
    logic [7:0] first_b;
    logic       nos_b, ovf_b, valid_b;

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t last_res;

    always #5 clk = ~clk;

    spike_rate_decoder dut_a (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike),
        .window_len(window_len), .window_load(window_load), .read_ack(read_ack),
        .count_out(count_a), .first_spike(first_a), .no_spike(nos_a),
        .overflow(ovf_a), .valid(valid_a)
    );

    spike_rate_decoder #(.COUNT_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike),
        .window_len(window_len), .window_load(window_load), .read_ack(read_ack),
        .count_out(count_b), .first_spike(first_b), .no_spike(nos_b),
        .overflow(ovf_b), .valid(valid_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set, outputs sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input logic s);
        enable = 1'b1;
        spike  = s;
        step();
        enable = 1'b0;
        spike  = 1'b0;
    endtask

    task automatic ack();
        read_ack = 1'b1;
        step();
        read_ack = 1'b0;
    endtask

    task automatic load(input logic [7:0] len);
        window_len  = len;
        window_load = 1'b1;
        step();
        window_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_count"}, count_a, 0);
        check({tag, "_first"}, first_a, 0);
        check({tag, "_nospike"}, nos_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
        check({tag, "_valid"}, valid_a, 0);
    endtask

    // Pops the oldest expected result and compares it against the selected instance.
    task automatic expect_result(input string tag, input bit use_b);
        res_t exp;
        res_t obs;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=result expected=scoreboard_entry", tag);
            return;
        end
        exp = sb_q.pop_front();
        if (use_b) obs = '{cnt: {6'b0, count_b}, first: first_b, nos: nos_b, ovf: ovf_b};
        else       obs = '{cnt: count_a, first: first_a, nos: nos_a, ovf: ovf_a};
        check({tag, "_valid"}, use_b ? valid_b : valid_a, 1);
        check({tag, "_count"}, obs.cnt, exp.cnt);
        check({tag, "_first"}, obs.first, exp.first);
        check({tag, "_nospike"}, obs.nos, exp.nos);
        check({tag, "_ovf"}, obs.ovf, exp.ovf);
        if (!use_b) last_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_outputs_zero("reset");

        // Window 4, spikes 0,1,0,1
        load(8'd4);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        check("w4_not_yet_valid", valid_a, 0);
        sb_q.push_back('{cnt: 8'd2, first: 8'd1, nos: 1'b0, ovf: 1'b0});
        tick(1'b1);
        expect_result("w4", 1'b0);

        // HOLD ignores ticks; result stable until ack
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("hold_valid", valid_a, 1);
        check("hold_count", count_a, last_res.cnt);
        check("hold_first", first_a, last_res.first);
        ack();
        check("ack_valid", valid_a, 0);
        check("ack_count_kept", count_a, 2);
        for (int i = 0; i < 3; i++) tick(1'b0);
        sb_q.push_back('{cnt: 8'd0, first: 8'd0, nos: 1'b1, ovf: 1'b0});
        tick(1'b0);
        expect_result("silent", 1'b0);

        // window_load on the last tick wins over the window end
        ack();
        for (int i = 0; i < 3; i++) tick(1'b1);
        window_len  = 8'd4;
        window_load = 1'b1;
        tick(1'b1);
        window_load = 1'b0;
        check("load_at_end_valid", valid_a, 0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        sb_q.push_back('{cnt: 8'd4, first: 8'd0, nos: 1'b0, ovf: 1'b0});
        tick(1'b1);
        expect_result("after_restart", 1'b0);

        // Mid-window reload with length 0 becomes window 1
        ack();
        load(8'd8);
        for (int i = 0; i < 5; i++) tick(1'b1);
        load(8'd0);
        check("len0_no_result", valid_a, 0);
        sb_q.push_back('{cnt: 8'd1, first: 8'd0, nos: 1'b0, ovf: 1'b0});
        tick(1'b1);
        expect_result("win1_spike", 1'b0);
        ack();
        sb_q.push_back('{cnt: 8'd0, first: 8'd0, nos: 1'b1, ovf: 1'b0});
        tick(1'b0);
        expect_result("win1_quiet", 1'b0);

        // Non-tick cycles with spike high must be ignored in COUNT
        ack();
        load(8'd3);
        tick(1'b0);
        spike = 1'b1;
        read_ack = 1'b1;
        step();
        step();
        step();
        spike = 1'b0;
        read_ack = 1'b0;
        check("idle_no_valid", valid_a, 0);
        tick(1'b1);
        sb_q.push_back('{cnt: 8'd2, first: 8'd1, nos: 1'b0, ovf: 1'b0});
        tick(1'b1);
        expect_result("enable_gap", 1'b0);

        // window_load and read_ack together in HOLD
        window_len  = 8'd2;
        window_load = 1'b1;
        read_ack    = 1'b1;
        step();
        window_load = 1'b0;
        read_ack    = 1'b0;
        check("load_ack_valid", valid_a, 0);
        tick(1'b1);
        sb_q.push_back('{cnt: 8'd1, first: 8'd0, nos: 1'b0, ovf: 1'b0});
        tick(1'b0);
        expect_result("load_ack_win", 1'b0);

        // Reset in HOLD; window returns to 16
        check("pre_reset_valid", valid_a, 1);
        do_reset();
        check_outputs_zero("hold_reset");
        for (int i = 0; i < 15; i++) tick(1'b0);
        check("w16_not_yet", valid_a, 0);
        sb_q.push_back('{cnt: 8'd1, first: 8'd15, nos: 1'b0, ovf: 1'b0});
        tick(1'b1);
        expect_result("w16", 1'b0);

        // Saturation: both instances, window 6 of continuous spikes
        do_reset();
        load(8'd6);
        for (int i = 0; i < 5; i++) tick(1'b1);
        sb_q.push_back('{cnt: 8'd6, first: 8'd0, nos: 1'b0, ovf: 1'b0});
        sb_q.push_back('{cnt: 8'd3, first: 8'd0, nos: 1'b0, ovf: 1'b1});
        tick(1'b1);
        expect_result("sat_wide", 1'b0);
        expect_result("sat_narrow", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
